// File: rtl/lc_line_server_pkg.sv
// Shared types and constants for the last-level line server.
package lc_line_server_pkg;

  localparam int unsigned CACHE_LINE_BYTES = 64;
  localparam int unsigned LineBits         = CACHE_LINE_BYTES * 8;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } lc_state_e;

  typedef enum logic {
    ClL1i = 1'b0,
    ClL1d = 1'b1
  } lc_client_e;

  typedef struct packed {
    logic [63:0]         addr;
    logic                we;
    logic [LineBits-1:0] value;
  } lc_req_t;

endpackage

// File: rtl/lc_rr_arbiter.sv
// Two-way round-robin arbiter; bit 0 is l1i, bit 1 is l1d.
module lc_rr_arbiter
  import lc_line_server_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  lc_client_e last_q;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_q == ClL1d) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ClL1d;
    end else if (accept && (grant != 2'b00)) begin
      last_q <= grant[1] ? ClL1d : ClL1i;
    end
  end

endmodule

// File: rtl/lc_line_server.sv
// Line-granular backing store serving one L1I/L1D request at a time with fixed latency.
module lc_line_server
  import lc_line_server_pkg::*;
#(
  parameter int unsigned CACHE_LINE_BYTES = 64,
  parameter int unsigned MEM_SIZE         = 4096,
  parameter int unsigned LATENCY          = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_N_in,

  input  logic                          l1i_req_valid_in,
  output logic                          l1i_req_ready_out,
  input  logic [63:0]                   l1i_req_addr_in,
  input  logic                          l1i_req_we_in,
  input  logic [CACHE_LINE_BYTES*8-1:0] l1i_req_value_in,
  output logic                          l1i_resp_valid_out,
  input  logic                          l1i_resp_ready_in,
  output logic [63:0]                   l1i_resp_addr_out,
  output logic [CACHE_LINE_BYTES*8-1:0] l1i_resp_value_out,

  input  logic                          l1d_req_valid_in,
  output logic                          l1d_req_ready_out,
  input  logic [63:0]                   l1d_req_addr_in,
  input  logic                          l1d_req_we_in,
  input  logic [CACHE_LINE_BYTES*8-1:0] l1d_req_value_in,
  output logic                          l1d_resp_valid_out,
  input  logic                          l1d_resp_ready_in,
  output logic [63:0]                   l1d_resp_addr_out,
  output logic [CACHE_LINE_BYTES*8-1:0] l1d_resp_value_out
);

  localparam int unsigned W     = CACHE_LINE_BYTES * 8;
  localparam int unsigned Lines = MEM_SIZE / CACHE_LINE_BYTES;
  localparam int unsigned OffW  = $clog2(CACHE_LINE_BYTES);
  localparam int unsigned AddrW = $clog2(MEM_SIZE);
  localparam int unsigned IdxW  = AddrW - OffW;
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  lc_state_e        state_q;
  logic [CntW-1:0]  cnt_q;
  lc_client_e       owner_q;
  logic [IdxW-1:0]  idx_q;
  logic             oor_q;
  logic             we_q;
  logic [63:0]      addr_q;
  logic [W-1:0]     wdata_q;
  logic [W-1:0]     rdata_q;

  logic [W-1:0]     mem [Lines];

  logic             idle;
  logic [1:0]       grant;
  logic             accept;
  logic             done;
  logic             resp_ready;
  lc_req_t          sel_req;

  assign idle   = (state_q == StIdle);
  assign accept = idle && (grant != 2'b00);
  assign done   = (state_q == StBusy) && (cnt_q == '0);

  lc_rr_arbiter u_arb (
    .clk    (clk_in),
    .rst_n  (rst_N_in),
    .req    ({l1d_req_valid_in, l1i_req_valid_in} & {2{idle}}),
    .accept (accept),
    .grant  (grant)
  );

  assign l1i_req_ready_out = grant[0];
  assign l1d_req_ready_out = grant[1];

  always_comb begin
    sel_req = '{addr: l1i_req_addr_in, we: l1i_req_we_in, value: l1i_req_value_in};
    if (grant[1]) begin
      sel_req = '{addr: l1d_req_addr_in, we: l1d_req_we_in, value: l1d_req_value_in};
    end
  end

  assign resp_ready = (owner_q == ClL1d) ? l1d_resp_ready_in : l1i_resp_ready_in;

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      owner_q <= ClL1i;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            owner_q <= grant[1] ? ClL1d : ClL1i;
            addr_q  <= sel_req.addr & ~64'(CACHE_LINE_BYTES - 1);
            idx_q   <= sel_req.addr[AddrW-1:OffW];
            oor_q   <= (sel_req.addr >= 64'(MEM_SIZE));
            we_q    <= sel_req.we;
            wdata_q <= sel_req.value;
            cnt_q   <= CntW'(LATENCY - 1);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            if (we_q) begin
              state_q <= StIdle;
            end else begin
              // Out-of-range reads return zero with unchanged timing.
              rdata_q <= oor_q ? '0 : mem[idx_q];
              state_q <= StResp;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Store is not reset; a reset before the final BUSY cycle keeps the write from landing.
  always_ff @(posedge clk_in) begin
    if (done && we_q && !oor_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign l1i_resp_valid_out = (state_q == StResp) && (owner_q == ClL1i);
  assign l1d_resp_valid_out = (state_q == StResp) && (owner_q == ClL1d);
  assign l1i_resp_addr_out  = l1i_resp_valid_out ? addr_q : '0;
  assign l1d_resp_addr_out  = l1d_resp_valid_out ? addr_q : '0;
  assign l1i_resp_value_out = l1i_resp_valid_out ? rdata_q : '0;
  assign l1d_resp_value_out = l1d_resp_valid_out ? rdata_q : '0;

endmodule

// File: tb/tb_lc_line_server.sv
// Scoreboard bench for lc_line_server: directed traffic on a LATENCY=4 and a LATENCY=1 instance.
module tb_lc_line_server;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance signals: i_* = l1i, d_* = l1d.
  logic         i_v, i_rdy, i_we, i_rv, i_rr;
  logic [63:0]  i_addr, i_ra;
  logic [511:0] i_val, i_rval;
  logic         d_v, d_rdy, d_we, d_rv, d_rr;
  logic [63:0]  d_addr, d_ra;
  logic [511:0] d_val, d_rval;
  // LATENCY=1 instance: e_* = l1i, f_* = l1d (idle).
  logic         e_v, e_rdy, e_we, e_rv, e_rr;
  logic [63:0]  e_addr, e_ra;
  logic [511:0] e_val, e_rval;
  logic         f_v, f_rdy, f_we, f_rv, f_rr;
  logic [63:0]  f_addr, f_ra;
  logic [511:0] f_val, f_rval;

  lc_line_server #(.CACHE_LINE_BYTES(64), .MEM_SIZE(4096), .LATENCY(LAT)) dut (
    .clk_in(clk), .rst_N_in(rst_n),
    .l1i_req_valid_in(i_v), .l1i_req_ready_out(i_rdy), .l1i_req_addr_in(i_addr),
    .l1i_req_we_in(i_we), .l1i_req_value_in(i_val), .l1i_resp_valid_out(i_rv),
    .l1i_resp_ready_in(i_rr), .l1i_resp_addr_out(i_ra), .l1i_resp_value_out(i_rval),
    .l1d_req_valid_in(d_v), .l1d_req_ready_out(d_rdy), .l1d_req_addr_in(d_addr),
    .l1d_req_we_in(d_we), .l1d_req_value_in(d_val), .l1d_resp_valid_out(d_rv),
    .l1d_resp_ready_in(d_rr), .l1d_resp_addr_out(d_ra), .l1d_resp_value_out(d_rval)
  );

  lc_line_server #(.CACHE_LINE_BYTES(64), .MEM_SIZE(4096), .LATENCY(1)) dut1 (
    .clk_in(clk), .rst_N_in(rst_n),
    .l1i_req_valid_in(e_v), .l1i_req_ready_out(e_rdy), .l1i_req_addr_in(e_addr),
    .l1i_req_we_in(e_we), .l1i_req_value_in(e_val), .l1i_resp_valid_out(e_rv),
    .l1i_resp_ready_in(e_rr), .l1i_resp_addr_out(e_ra), .l1i_resp_value_out(e_rval),
    .l1d_req_valid_in(f_v), .l1d_req_ready_out(f_rdy), .l1d_req_addr_in(f_addr),
    .l1d_req_we_in(f_we), .l1d_req_value_in(f_val), .l1d_resp_valid_out(f_rv),
    .l1d_resp_ready_in(f_rr), .l1d_resp_addr_out(f_ra), .l1d_resp_value_out(f_rval)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int           c;
    logic [63:0]  a;
    logic [511:0] v;
    int           due;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [511:0] PA5 = {64{8'hA5}};
  localparam logic [511:0] P0  = {16{32'h0BADF00D}};
  localparam logic [511:0] P2  = {16{32'h12345678}};
  localparam logic [511:0] P3  = {64{8'h3C}};
  localparam logic [511:0] PFF = {64{8'hFF}};

  // Monitor: pops the scoreboard on every response handshake.
  int  rise [2];
  bit  prev [2];
  always @(negedge clk) begin
    exp_t e;
    bit v, rr, other;
    logic [63:0] ra;
    logic [511:0] rv;
    if (!rst_n) begin
      prev[0] = 1'b0;
      prev[1] = 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        v     = (c == 1) ? d_rv : i_rv;
        rr    = (c == 1) ? d_rr : i_rr;
        other = (c == 1) ? i_rv : d_rv;
        ra    = (c == 1) ? d_ra : i_ra;
        rv    = (c == 1) ? d_rval : i_rval;
        if (v && !prev[c]) rise[c] = cyc;
        prev[c] = v;
        if (v) begin
          chk("non_owner_valid_low", 512'(other), 512'(0));
          if (rr) begin
            if (exp_q.size() == 0) begin
              checks++;
              fails++;
              $display("FAIL unexpected_resp client=%0d actual=response required=none", c);
            end else begin
              e = exp_q.pop_front();
              chk("resp_client", 512'(c), 512'(e.c));
              chk("resp_addr", 512'(ra), 512'(e.a));
              chk("resp_value", rv, e.v);
              chk("resp_latency", 512'(rise[c]), 512'(e.due));
            end
          end
        end
      end
    end
  end

  task automatic drive(input int c, input logic v, input logic [63:0] a, input logic we,
                       input logic [511:0] val);
    if (c == 1) begin
      d_v = v; d_addr = a; d_we = we; d_val = val;
    end else begin
      i_v = v; i_addr = a; i_we = we; i_val = val;
    end
  endtask

  task automatic req(input int c, input logic [63:0] a, input logic we, input logic [511:0] v,
                     input logic [511:0] expv, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    drive(c, 1'b1, a, we, v);
    #1;
    while (!((c == 1) ? d_rdy : i_rdy) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL req_timeout client=%0d actual=no_ready required=ready", c);
      drive(c, 1'b0, a, we, v);
    end else begin
      @(posedge clk);
      #1;
      if (track && !we) exp_q.push_back('{c, a & ~64'h3f, expv, cyc + LAT});
      // Scramble fields after handshake; the DUT must have latched them already.
      drive(c, 1'b0, ~a, ~we, ~v);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lat1_test();
    int acc, prev_acc, nacc;
    bit have;
    // Reads: accept, response the next cycle, handshake, then re-accept.
    nacc = 0; have = 1'b0; prev_acc = 0;
    @(negedge clk);
    e_addr = 64'h1000; e_we = 1'b0; e_val = PFF; e_v = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (e_rv) begin
        chk("lat1_resp_cycle", 512'(cyc), 512'(prev_acc + 1));
        chk("lat1_resp_value", e_rval, 512'(0));
      end
      if (e_rdy) begin
        acc = cyc + 1;
        if (have) chk("lat1_read_spacing", 512'(acc - prev_acc), 512'(3));
        prev_acc = acc;
        have = 1'b1;
        nacc++;
      end
    end
    chk("lat1_read_accepts", 512'(nacc), 512'(5));
    e_v = 1'b0;
    repeat (4) @(negedge clk);
    // Writes: no response, so one accept every LATENCY+1 cycles.
    nacc = 0; have = 1'b0;
    e_we = 1'b1; e_v = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("lat1_write_no_resp", 512'(e_rv), 512'(0));
      if (e_rdy) begin
        acc = cyc + 1;
        if (have) chk("lat1_write_spacing", 512'(acc - prev_acc), 512'(2));
        prev_acc = acc;
        have = 1'b1;
        nacc++;
      end
    end
    chk("lat1_write_accepts", 512'(nacc), 512'(5));
    e_v = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_v = 0; i_addr = 0; i_we = 0; i_val = 0; i_rr = 1;
    d_v = 0; d_addr = 0; d_we = 0; d_val = 0; d_rr = 1;
    e_v = 0; e_addr = 0; e_we = 0; e_val = 0; e_rr = 1;
    f_v = 0; f_addr = 0; f_we = 0; f_val = 0; f_rr = 1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 512'({i_rdy, d_rdy, i_rv, d_rv, e_rdy, e_rv}), 512'(0));
    chk("reset_addr", 512'(i_ra | d_ra), 512'(0));
    chk("reset_value", i_rval | d_rval, 512'(0));
    rst_n = 1'b1;

    // Fill lines, then read-after-write through the other client.
    req(1, 64'h0,  1'b1, P0,  '0, 1'b1);
    req(0, 64'h80, 1'b1, P2,  '0, 1'b1);
    req(1, 64'h40, 1'b1, PA5, '0, 1'b1);
    req(0, 64'h47, 1'b0, '0,  PA5, 1'b1);
    drain();

    // Response backpressure.
    @(posedge clk); #1; i_rr = 1'b0;
    req(0, 64'h10, 1'b0, '0, P0, 1'b1);
    n = 0;
    while (!i_rv && n < 50) begin @(negedge clk); n++; end
    chk("bp_resp_seen", 512'(i_rv), 512'(1));
    drive(1, 1'b1, 64'h40, 1'b0, '0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("bp_valid_held", 512'(i_rv), 512'(1));
      chk("bp_addr_held", 512'(i_ra), 512'(0));
      chk("bp_value_held", i_rval, P0);
      chk("bp_no_accept", 512'(d_rdy), 512'(0));
    end
    drive(1, 1'b0, 64'h40, 1'b0, '0);
    @(posedge clk); #1; i_rr = 1'b1;
    drain();

    // Out-of-range write is dropped; read returns zero; line 0 untouched.
    req(1, 64'h1000, 1'b1, PFF, '0, 1'b1);
    req(0, 64'h1000, 1'b0, '0,  '0, 1'b1);
    req(0, 64'h0,    1'b0, '0,  P0, 1'b1);
    drain();

    // Reset mid-read: outputs clear immediately and no response follows.
    req(0, 64'h80, 1'b0, '0, '0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_read_ctrl", 512'({i_rdy, d_rdy, i_rv, d_rv}), 512'(0));
    chk("rst_mid_read_data", 512'(i_ra) | i_rval, 512'(0));
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("no_resp_after_reset", 512'(i_rv), 512'(0));
    end

    // Reset mid-write: the store keeps its old line.
    req(1, 64'h80, 1'b1, P3, '0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    req(0, 64'h80, 1'b0, '0, P2, 1'b1);
    drain();

    // Both clients contend from reset: grants go I, D, I, D.
    pulse_reset();
    fork
      begin
        req(0, 64'h0,  1'b0, '0, P0,  1'b1);
        req(0, 64'h40, 1'b0, '0, PA5, 1'b1);
      end
      begin
        req(1, 64'h80, 1'b0, '0, P2,  1'b1);
        req(1, 64'h47, 1'b0, '0, PA5, 1'b1);
      end
    join
    drain();

    lat1_test();

    chk("scoreboard_empty", 512'(exp_q.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
